cache_port_arbiter: RTL and testbench

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/cache_port_arbiter_pkg.sv | 22 ++
 rtl/cache_port_arbiter_rr_arbiter.sv | 24 ++
 rtl/cache_port_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// cache_port_arbiter_pkg: shared cache widths, controller constants and arbiter FSM encoding
package cache_port_arbiter_pkg;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_BYTES = 64;
  localparam int NUM_SETS   = 256;
  localparam int NUM_WAYS   = 4;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rw;
  } cache_req_t;
endpackage

// File: rtl/cache_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot pick of the first set request at or after rr_ptr, wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] winner
);
  logic found;
  int   k;
  always_comb begin
    winner = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        winner[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin arbitration of NUM_REQ requesters onto one cache port with watchdog
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_rw,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      timeout_err,
  output logic                      c_req,
  output logic [ADDR_W-1:0]         c_addr,
  output logic [DATA_W-1:0]         c_wdata,
  output logic                      c_rw,
  input  logic [DATA_W-1:0]         c_rdata,
  input  logic                      c_ready
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  cache_req_t        creq_q, creq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_REQ-1:0] win;
  cache_req_t        sel;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (win)
  );

  always_comb begin
    sel     = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win[k]) begin
        sel.addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel.wdata = req_wdata[k*DATA_W +: DATA_W];
        sel.rw    = req_rw[k];
        win_idx   = PW'(k);
      end
    end
    next_ptr = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    creq_d      = creq_q;
    rdata_d     = rdata_q;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d    = win;
          creq_d   = sel;
          rr_ptr_d = next_ptr;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (c_ready) begin
          rdata_d = creq_q.rw ? rdata_q : c_rdata;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          timeout_err = 1'b1;
          rdata_d     = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      creq_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      creq_q   <= creq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == RESP) ? gnt_q : '0;
  assign c_req   = (state_q == ISSUE);
  assign c_addr  = creq_q.addr;
  assign c_wdata = creq_q.wdata;
  assign c_rw    = creq_q.rw;
  assign rdata   = rdata_q;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed scoreboard bench for the cache port arbiter
module tb_cache_port_arbiter;
  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_rw;
  logic [3:0]   gnt;
  logic [3:0]   done;
  logic [31:0]  rdata;
  logic         timeout_err;
  logic         c_req;
  logic [31:0]  c_addr;
  logic [31:0]  c_wdata;
  logic         c_rw;
  logic [31:0]  c_rdata;
  logic         c_ready;

  cache_port_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rw      (req_rw),
    .gnt         (gnt),
    .done        (done),
    .rdata       (rdata),
    .timeout_err (timeout_err),
    .c_req       (c_req),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_rw        (c_rw),
    .c_rdata     (c_rdata),
    .c_ready     (c_ready)
  );

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
    logic [31:0] rdata;
    int          to;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          rdelay;
  logic [31:0] rkey;
  int          stray_n;
  logic [31:0] ra [4] = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0308, 32'h0000_040C};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [31:0] a, input logic [31:0] w,
                      input logic rw, input logic [31:0] rd, input int to);
    exp_t e;
    e.gnt = g; e.addr = a; e.wdata = w; e.rw = rw; e.rdata = rd; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic wait_creq(input int left, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (c_req && exp_q.size() == left) return;
    end
    check("wait_c_req_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    check("wait_done_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // cache model: answers rdelay cycles after c_req with addr^rkey; rdelay<0 never answers
  initial begin
    int seen;
    int d;
    logic [31:0] a;
    seen = 0;
    c_ready = 1'b0;
    c_rdata = '0;
    forever begin
      @(negedge clk);
      if (c_req && rst_n && rdelay >= 0) begin
        d = rdelay;
        a = c_addr;
        repeat (d) @(negedge clk);
        c_rdata = a ^ rkey;
        c_ready = 1'b1;
        @(negedge clk);
        c_ready = 1'b0;
      end else if (stray_n != seen) begin
        seen++;
        c_rdata = 32'hDEAD_BEEF;
        c_ready = 1'b1;
        @(negedge clk);
        c_ready = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    logic [3:0]  cap_gnt;
    logic [64:0] cap;
    logic        cap_on;
    logic        stab_ok;
    int          to_cnt;
    cap_on = 1'b0; stab_ok = 1'b1; to_cnt = 0; cap = '0; cap_gnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cap_on = 1'b0;
        to_cnt = 0;
      end else begin
        if (timeout_err) to_cnt++;
        if (cap_on && {c_addr, c_wdata, c_rw} !== cap) stab_ok = 1'b0;
        if (c_req) begin
          if (exp_q.size() == 0) check("unexpected_c_req", {60'd0, gnt}, 64'd0);
          else begin
            e = exp_q[0];
            check("grant", {60'd0, gnt}, {60'd0, e.gnt});
            check("c_addr", {32'd0, c_addr}, {32'd0, e.addr});
            check("c_wdata", {32'd0, c_wdata}, {32'd0, e.wdata});
            check("c_rw", {63'd0, c_rw}, {63'd0, e.rw});
          end
          cap = {c_addr, c_wdata, c_rw};
          cap_gnt = gnt;
          cap_on = 1'b1;
          stab_ok = 1'b1;
          to_cnt = 0;
        end
        if (done != 4'd0) begin
          if (exp_q.size() == 0) check("spurious_done", {60'd0, done}, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("done", {60'd0, done}, {60'd0, e.gnt});
            check("done_vs_gnt", {60'd0, done}, {60'd0, cap_gnt});
            check("rdata", {32'd0, rdata}, {32'd0, e.rdata});
            check("timeout_pulses", 64'(to_cnt), 64'(e.to));
            check("c_fields_stable", {63'd0, stab_ok}, 64'd1);
          end
          cap_on = 1'b0;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; req_addr = '0; req_wdata = '0; req_rw = '0;
    rdelay = -1; rkey = '0; stray_n = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {57'd0, gnt, done, c_req, c_rw, timeout_err}, 64'd0);
    check("reset_rdata", {32'd0, rdata}, 64'd0);
    check("reset_c_addr", {32'd0, c_addr}, 64'd0);
    check("reset_c_wdata", {32'd0, c_wdata}, 64'd0);

    for (int k = 0; k < 4; k++) req_addr[k*32 +: 32] = ra[k];
    rkey = 32'hA5A5_0000;
    rdelay = 1;
    req = 4'hF;
    push(4'b0001, ra[0], 32'd0, 1'b0, ra[0] ^ rkey, 0);
    push(4'b0010, ra[1], 32'd0, 1'b0, ra[1] ^ rkey, 0);
    push(4'b0100, ra[2], 32'd0, 1'b0, ra[2] ^ rkey, 0);
    push(4'b1000, ra[3], 32'd0, 1'b0, ra[3] ^ rkey, 0);
    push(4'b0001, ra[0], 32'd0, 1'b0, ra[0] ^ rkey, 0);
    push(4'b0010, ra[1], 32'd0, 1'b0, ra[1] ^ rkey, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_creq(1, 200);
    req = '0;
    wait_empty(50);
    repeat (2) @(negedge clk);

    req_addr[31:0] = 32'h0000_1040;
    rkey = 32'h0;
    rdelay = 3;
    push(4'b0001, 32'h0000_1040, 32'd0, 1'b0, 32'h0000_1040, 0);
    req = 4'b0001;
    @(negedge clk);
    check("latency_c_req", {63'd0, c_req}, 64'd1);
    req = '0;
    @(negedge clk);
    check("c_req_one_cycle", {63'd0, c_req}, 64'd0);
    repeat (2) @(negedge clk);
    check("done_not_early", {60'd0, done}, 64'd0);
    @(negedge clk);
    check("latency_done", {60'd0, done}, 64'd1);
    wait_empty(20);
    repeat (2) @(negedge clk);

    req_addr[95:64] = 32'h0000_2000;
    req_wdata[95:64] = 32'hCAFE_F00D;
    req_rw[2] = 1'b1;
    rdelay = 5;
    push(4'b0100, 32'h0000_2000, 32'hCAFE_F00D, 1'b1, 32'h0000_1040, 0);
    req = 4'b0100;
    wait_creq(1, 20);
    req = '0;
    wait_empty(30);
    req_rw = '0;
    repeat (2) @(negedge clk);

    req_addr[31:0] = 32'h0000_3000;
    rdelay = -1;
    push(4'b0001, 32'h0000_3000, 32'd0, 1'b0, 32'h0, 1);
    req = 4'b0001;
    wait_creq(1, 20);
    req = '0;
    wait_empty(100);
    @(negedge clk);
    check("idle_after_timeout", {59'd0, gnt, c_req}, 64'd0);
    repeat (2) @(negedge clk);

    stray_n = 1;
    repeat (4) @(negedge clk);
    check("stray_c_ready_ignored", {55'd0, done, gnt, c_req}, 64'd0);

    req_addr[127:96] = 32'h0000_4444;
    rkey = 32'hA5A5_0000;
    rdelay = 6;
    push(4'b1000, 32'h0000_4444, 32'd0, 1'b0, 32'h0000_4444 ^ 32'hA5A5_0000, 0);
    req = 4'b1000;
    wait_creq(1, 20);
    repeat (2) @(negedge clk);
    req = '0;
    wait_empty(30);
    repeat (2) @(negedge clk);

    req_addr[63:32] = 32'h0000_5550;
    rdelay = -1;
    push(4'b0010, 32'h0000_5550, 32'd0, 1'b0, 32'h0, 0);
    req = 4'b0110;
    wait_creq(1, 20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {57'd0, gnt, done, c_req, c_rw, timeout_err}, 64'd0);
    check("async_reset_data", {32'd0, rdata | c_addr | c_wdata}, 64'd0);
    exp_q.delete();
    rdelay = 2;
    push(4'b0010, 32'h0000_5550, 32'd0, 1'b0, 32'h0000_5550 ^ 32'hA5A5_0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_creq(1, 20);
    req = '0;
    wait_empty(30);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
